// File: rtl/dmem_responder_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_responder_pkg
// Brief   : MMIO offsets, STATUS bit positions and byte-lane merge helper
//           shared by the data-memory responder and its timer block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_responder_pkg;

    localparam logic [1:0]  DMEM_MTIME         = 2'd0;
    localparam logic [1:0]  DMEM_LEDS          = 2'd1;
    localparam logic [1:0]  DMEM_MTIMECMP      = 2'd2;
    localparam logic [1:0]  DMEM_STATUS        = 2'd3;

    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_IRQ_EN_BIT  = 1;

    localparam logic [31:0] MTIMECMP_RST       = 32'hFFFF_FFFF;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_timer.sv
//------------------------------------------------------------------------------
// Module  : dmem_timer
// Brief   : Free-running mtime, mtimecmp compare, STATUS (pending/irq_en) and
//           interrupt generation with byte-lane write port.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_timer
    import dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] mtime_q,    mtime_d;
    logic [31:0] mtimecmp_q, mtimecmp_d;
    logic        pending_q,  pending_d;
    logic        irq_en_q,   irq_en_d;
    logic        we_mtime;
    logic        we_cmp;
    logic        we_status;

    always_comb begin
        we_mtime   = wr_en && (offset == DMEM_MTIME) && (wstrb != 4'b0000);
        we_cmp     = wr_en && (offset == DMEM_MTIMECMP);
        we_status  = wr_en && (offset == DMEM_STATUS) && wstrb[0];

        mtime_d    = we_mtime ? byte_merge(mtime_q, wdata, wstrb) : mtime_q + 32'd1;
        mtimecmp_d = we_cmp ? byte_merge(mtimecmp_q, wdata, wstrb) : mtimecmp_q;

        // A compare match in the same cycle as a W1C keeps pending set.
        pending_d  = (mtime_q == mtimecmp_q) ||
                     (pending_q && !(we_status && wdata[STATUS_PENDING_BIT]));
        irq_en_d   = we_status ? wdata[STATUS_IRQ_EN_BIT] : irq_en_q;

        rdata = '0;
        case (offset)
            DMEM_MTIME:    rdata = we_mtime ? mtime_d : mtime_q;
            DMEM_MTIMECMP: rdata = mtimecmp_d;
            DMEM_STATUS: begin
                rdata[STATUS_PENDING_BIT] = we_status ? pending_d : pending_q;
                rdata[STATUS_IRQ_EN_BIT]  = irq_en_d;
            end
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            pending_q  <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pending_q  <= pending_d;
            irq_en_q   <= irq_en_d;
        end
    end

    assign irq = pending_q & irq_en_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module  : dmem_responder
// Brief   : SCPU data-port responder: byte-lane RAM, LED/timer MMIO page,
//           one-cycle registered read data. Timer present when DMEM_TIMER_EN
//           is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] MMIO_PAGE = 16'hFFFF,
    parameter int          LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_w,
    input  logic [31:0]      Addr_out,
    input  logic [31:0]      Data_out,
    input  logic [3:0]       DWea,
    output logic [31:0]      Data_in,
    output logic             INT,
    output logic [LED_W-1:0] leds,
    output logic             addr_err
);

    logic [31:0]       ram_q [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_word;
    logic              ram_hit;
    logic              mmio_hit;
    logic              ram_we;
    logic              mmio_we;
    logic [1:0]        mmio_off;
    logic [31:0]       leds_word;
    logic [31:0]       leds_merged;
    logic [31:0]       timer_rdata;

    logic [31:0]       data_in_q,  data_in_d;
    logic [LED_W-1:0]  leds_q,     leds_d;
    logic              addr_err_q, addr_err_d;

    logic              unused_addr;
    assign unused_addr = ^{Addr_out[15:4], Addr_out[1:0]};

    always_comb begin
        ram_hit  = (Addr_out[31:ADDR_W+2] == '0);
        mmio_hit = (Addr_out[31:16] == MMIO_PAGE);
        ram_idx  = Addr_out[ADDR_W+1:2];
        mmio_off = Addr_out[3:2];
        ram_we   = mem_w && ram_hit;
        mmio_we  = mem_w && mmio_hit;
        ram_word = ram_q[ram_idx];

        leds_word              = '0;
        leds_word[LED_W-1:0]   = leds_q;
        leds_merged            = byte_merge(leds_word, Data_out, DWea);
        leds_d                 = (mmio_we && (mmio_off == DMEM_LEDS)) ?
                                 leds_merged[LED_W-1:0] : leds_q;

        // Write-first: a read of the word being stored returns the merged value.
        data_in_d = '0;
        if (ram_hit) begin
            data_in_d = ram_we ? byte_merge(ram_word, Data_out, DWea) : ram_word;
        end else if (mmio_hit) begin
            if (mmio_off == DMEM_LEDS) begin
                data_in_d            = '0;
                data_in_d[LED_W-1:0] = leds_d;
            end else begin
                data_in_d = timer_rdata;
            end
        end

        addr_err_d = addr_err_q || !(ram_hit || mmio_hit);
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (DWea[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= Data_out[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_in_q  <= '0;
            leds_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            data_in_q  <= data_in_d;
            leds_q     <= leds_d;
            addr_err_q <= addr_err_d;
        end
    end

`ifdef DMEM_TIMER_EN
    dmem_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (mmio_we),
        .offset (mmio_off),
        .wdata  (Data_out),
        .wstrb  (DWea),
        .rdata  (timer_rdata),
        .irq    (INT)
    );
`else
    assign timer_rdata = '0;
    assign INT         = 1'b0;
`endif

    assign Data_in  = data_in_q;
    assign leds     = leds_q;
    assign addr_err = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_dmem_responder
// Brief   : Directed stimulus with a read-data scoreboard for dmem_responder.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [3:0]  DWea;
    logic [31:0] Data_in;
    logic        INT;
    logic [15:0] leds;
    logic        addr_err;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          tb_chk = 0;
    bit          chk_d  = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    dmem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .mem_w    (mem_w),
        .Addr_out (Addr_out),
        .Data_out (Data_out),
        .DWea     (DWea),
        .Data_in  (Data_in),
        .INT      (INT),
        .leds     (leds),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read data belongs to the request issued one edge earlier.
    always @(posedge clk) chk_d <= tb_chk;

    always @(negedge clk) begin
        if (chk_d) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got response, expected none");
            end else begin
                check(name_q.pop_front(), Data_in, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] we, input bit chk, input logic [31:0] exp,
                        input string nm);
        mem_w    = mw;
        Addr_out = a;
        Data_out = d;
        DWea     = we;
        tb_chk   = chk;
        if (chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        mem_w    = 1'b0;
        Addr_out = '0;
        Data_out = '0;
        DWea     = '0;
        tb_chk   = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        step(1'b1, a, d, we, 0, '0, "");
    endtask

    task automatic wrc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input logic [31:0] exp, input string nm);
        step(1'b1, a, d, we, 1, exp, nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        step(1'b0, a, '0, 4'h0, 1, exp, nm);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, '0, 4'h0, 0, '0, "");
    endtask

    localparam logic [31:0] A_MTIME  = 32'hFFFF_0000;
    localparam logic [31:0] A_LEDS   = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    initial begin
        int rise;
        rst      = 1'b0;
        mem_w    = 1'b0;
        Addr_out = '0;
        Data_out = '0;
        DWea     = '0;

        idle();
        idle();
        check("reset_data_in",  Data_in,  32'h0);
        check("reset_int",      {31'b0, INT}, 32'h0);
        check("reset_leds",     {16'b0, leds}, 32'h0);
        check("reset_addr_err", {31'b0, addr_err}, 32'h0);
        rst = 1'b1;
        idle();
`ifdef DMEM_TIMER_EN
        rd(A_MTIME, 32'd1, "mtime_after_reset");
`else
        rd(A_MTIME, 32'd0, "mtime_absent");
`endif

        // RAM byte lanes, write-first and boundaries
        wrc(32'h10, 32'h1122_3344, 4'hF, 32'h1122_3344, "ram_full_write_first");
        wrc(32'h10, 32'hAABB_CCDD, 4'b0010, 32'h1122_CC44, "ram_lane1_write_first");
        rd (32'h10, 32'h1122_CC44, "ram_lane1_read");
        wrc(32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h1122_CC44, "ram_no_lane_write");
        rd (32'h13, 32'h1122_CC44, "ram_low_bits_ignored");
        wr (32'h14, 32'h0000_0000, 4'hF);
        wr (32'h14, 32'h1234_5678, 4'b1001);
        rd (32'h14, 32'h1200_0078, "ram_lanes_0_3");
        wr (32'h3FFC, 32'hCAFE_F00D, 4'hF);
        rd (32'h3FFC, 32'hCAFE_F00D, "ram_last_word");
        wr (32'h0, 32'h55AA_55AA, 4'hF);
        rd (32'h0, 32'h55AA_55AA, "ram_word0");
        check("addr_err_clean", {31'b0, addr_err}, 32'h0);

        // LED register
        wrc(A_LEDS, 32'hDEAD_BEEF, 4'hF, 32'h0000_BEEF, "leds_write_first");
        check("leds_out", {16'b0, leds}, 32'h0000_BEEF);
        rd (A_LEDS, 32'h0000_BEEF, "leds_read");
        rd (32'hFFFF_ABC4, 32'h0000_BEEF, "leds_alias");
        wr (A_LEDS, 32'h0077_0012, 4'b0101);
        rd (A_LEDS, 32'h0000_BE12, "leds_lane_write");
        check("leds_out_lane", {16'b0, leds}, 32'h0000_BE12);

`ifdef DMEM_TIMER_EN
        // Interrupt: clear any stale pending before arming
        wr (A_MTIME, 32'd0, 4'hF);
        wr (A_CMP, 32'd50, 4'hF);
        wr (A_STATUS, 32'h3, 4'b0001);
        wr (A_MTIME, 32'd0, 4'hF);
        check("int_before_match", {31'b0, INT}, 32'h0);
        rise = 0;
        for (int n = 1; n <= 200 && rise == 0; n++) begin
            idle();
            if (INT === 1'b1) rise = n;
        end
        check("int_rise_cycle", rise, 32'd51);
        idle(); idle(); idle();
        check("int_held", {31'b0, INT}, 32'h1);
        wrc(A_STATUS, 32'h3, 4'b0001, 32'h2, "status_w1c_read");
        check("int_cleared", {31'b0, INT}, 32'h0);
        wr (A_CMP, 32'd300, 4'hF);
        wr (A_MTIME, 32'd300, 4'hF);
        wrc(A_STATUS, 32'h3, 4'b0001, 32'h3, "status_set_wins");
        check("int_set_wins", {31'b0, INT}, 32'h1);
        wrc(A_CMP, 32'h00AB_0000, 4'b0100, 32'h00AB_012C, "mtimecmp_lane2");

        // Wrap
        wr (A_MTIME, 32'hFFFF_FFFE, 4'hF);
        idle();
        rd (A_MTIME, 32'hFFFF_FFFF, "mtime_wrap_ff");
        rd (A_MTIME, 32'h0000_0000, "mtime_wrap_0");
        rd (A_MTIME, 32'h0000_0001, "mtime_wrap_1");
`else
        wrc(A_CMP, 32'h1234_5678, 4'hF, 32'h0, "mtimecmp_absent");
        rd (A_CMP, 32'h0, "mtimecmp_absent_read");
        wrc(A_STATUS, 32'h3, 4'hF, 32'h0, "status_absent");
        wr (A_MTIME, 32'h1111_1111, 4'hF);
        rd (A_MTIME, 32'h0, "mtime_absent_write");
        check("int_absent", {31'b0, INT}, 32'h0);
`endif

        // Unmapped accesses
        rd (32'h0000_4000, 32'h0, "unmapped_above_ram");
        check("addr_err_set", {31'b0, addr_err}, 32'h1);
        wr (32'h0000_4000, 32'h0, 4'hF);
        rd (32'h0, 32'h55AA_55AA, "ram_no_alias");
        rd (32'h8000_0000, 32'h0, "unmapped_read");
        wr (32'h8000_0010, 32'h0, 4'hF);
        wr (32'hFFFE_0004, 32'h0, 4'hF);
        rd (32'h10, 32'h1122_CC44, "ram_after_unmapped_write");
        check("leds_after_unmapped_write", {16'b0, leds}, 32'h0000_BE12);
        idle();
        check("addr_err_sticky", {31'b0, addr_err}, 32'h1);

        // Second reset: registers cleared, RAM retained
        rst = 1'b0;
        idle();
        idle();
        check("reset2_addr_err", {31'b0, addr_err}, 32'h0);
        check("reset2_leds", {16'b0, leds}, 32'h0);
        check("reset2_int", {31'b0, INT}, 32'h0);
        rst = 1'b1;
        rd (32'h10, 32'h1122_CC44, "ram_kept_over_reset");
        idle();
        idle();

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the SCPU data port.
- Consumes mem_w / Addr_out / Data_out / DWea from the FAM execution unit and returns Data_in with one-cycle registered latency.
- Contains a word-organised data RAM with byte-lane writes and a small MMIO register block: cycle timer, compare register, LED register and interrupt status.
- The timer drives the SCPU INT input.

Parameters:
- ADDR_W, 12: RAM word-address bits (4096 words, 16 KiB).
- MMIO_PAGE, 16'hFFFF: Addr_out[31:16] value that selects MMIO.
- LED_W, 16: width of the LED output register.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_w  in  1  store request this cycle.
- Addr_out  in  32  byte address from CPU.
- Data_out  in  32  store data from CPU; lane i = bits [8i+7:8i].
- DWea  in  4  byte-lane write enables, qualified by mem_w.
- Data_in  out  32  registered read data to CPU.
- INT  out  1  timer interrupt to CPU.
- leds  out  LED_W  LED register value.
- addr_err  out  1  sticky flag: access to an unmapped address.

Behaviour:
- Reset (rst==0 at a clock edge):
  - Data_in=0, INT=0, leds=0, addr_err=0.
  - mtime=0, mtimecmp=32'hFFFFFFFF, status=0.
  - RAM contents are not reset.
- Decode; Addr_out[1:0] is ignored for selection:
  - RAM when Addr_out[31:ADDR_W+2]==0.
  - MMIO when Addr_out[31:16]==MMIO_PAGE. Offset Addr_out[3:2]: 0 MTIME, 1 LEDS, 2 MTIMECMP, 3 STATUS. Addr_out[15:4] are don't-care, so registers alias within the page.
  - Anything else is unmapped.
- Reads:
  - Every cycle, Data_in <= word at the decoded address. DWea is ignored for reads; the CPU performs byte/half extraction.
  - Latency: address in cycle N, data visible in cycle N+1.
  - Unmapped reads return 0.
- Writes:
  - At the edge, when mem_w==1, each lane i with DWea[i]==1 takes Data_out lane i; other lanes are unchanged.
  - mem_w==1 with DWea==0 is a no-op.
  - Same-cycle read and write to the same word is write-first: Data_in in N+1 shows the merged new word.
- Unmapped access: writes are dropped. Any read or write with mem_w or any address to an unmapped region sets addr_err, which clears only on reset.
  - Read-side: addr_err is set whenever an unmapped address is presented and the CPU holds it. This is conservative by decision.
- MTIME:
  - Increments by 1 every cycle; wraps 32'hFFFFFFFF -> 0.
  - A write loads the byte-merged value; the increment is suppressed that cycle.
- MTIMECMP: read/write, byte-merged.
- LEDS: read/write.
  - Lanes above LED_W are ignored on write and read as 0.
  - leds output equals the register contents.
- STATUS:
  - bit0 = pending (W1C via lane 0).
  - bit1 = irq_en (R/W via lane 0).
  - bits 31:2 read 0.
- Pending:
  - Set at an edge when the current mtime==mtimecmp.
  - Set wins over a simultaneous W1C.
  - Pending sets regardless of irq_en.
- INT = pending & irq_en, driven from registered state. INT stays high until cleared or disabled.

Optional Feature:
- Macro DMEM_TIMER_EN.
- Defined: MTIME, MTIMECMP, STATUS and INT behave as above.
- Undefined:
  - The timer logic is absent and INT is tied to 0.
  - Offsets 0, 2 and 3 read 0 and ignore writes.
  - LEDS, RAM and addr_err are unchanged.

Decomposition:
- Shared package (def.vh): MMIO offsets (DMEM_MTIME=2'd0, DMEM_LEDS=2'd1, DMEM_MTIMECMP=2'd2, DMEM_STATUS=2'd3), STATUS bit indices, MTIMECMP reset value.
- One sub-module, dmem_timer: mtime, mtimecmp, status, INT generation, with byte-lane write inputs.
- RAM array and decode stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> Data_in=0, INT=0, leds=0, addr_err=0; MTIME reads 1 or 2 afterwards, consistent with a 1-cycle read.
- Byte write: word 0x10 = 32'h11223344, then mem_w=1, DWea=4'b0010, Data_out=32'hAABBCCDD at 0x10 -> next read 32'h1122CC44; same-cycle read returns it in N+1.
- Unmapped access: read 0x8000_0000 -> Data_in=0 and addr_err=1; a write there leaves RAM and MMIO unchanged; addr_err holds until reset.
- Interrupt: write MTIMECMP=50, STATUS=2'b10, MTIME=0 -> INT rises after the compare edge (~50 cycles) and stays high; W1C STATUS=2'b11 clears INT; a W1C coinciding with a match keeps pending=1.
- Wrap: write MTIME=32'hFFFFFFFE -> reads show FFFFFFFF then 0 then 1.
- LED register (LED_W=16): write LEDS 32'hDEADBEEF with DWea=4'hF -> leds=16'hBEEF; readback 32'h0000BEEF.
